param_receiver: RTL and testbench
=================================

PARAM_RECEIVER -- requirements
Module: param_receiver

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame, legal 1..16.
REQ-002 Parameter CLKS_PER_BIT, default 1, clk cycles per serial bit, legal >=1.
REQ-003 Parameter PARITY_MODE, default 0, 0 none / 1 even / 2 odd.
REQ-004 Parameter STOP_BITS, default 1, legal 1 or 2.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 rx  in  1  serial line; idle high, start bit low, LSB first.
REQ-008 data  out  DATA_W  received word; stable while valid=1.
REQ-009 valid  out  1  data holds an unconsumed word.
REQ-010 ready  in  1  consumer accepts data when valid&ready.
REQ-011 frame_err  out  1  one-cycle pulse: stop bit sampled low.
REQ-012 parity_err  out  1  one-cycle pulse: parity mismatch, stop bits good.
REQ-013 overrun  out  1  one-cycle pulse: frame completed while holding register full.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP, ERROR.
REQ-016 Detection cycle: IDLE with rx=0; it counts as start-bit cycle 0; H=(CLKS_PER_BIT-1)/2, integer division.
REQ-017 IDLE, rx=0: H=0 -> DATA with timer=CLKS_PER_BIT-1; else -> START with timer=H-1.
REQ-018 START: timer>0 -> decrement; timer=0: rx=0 -> DATA, timer=CLKS_PER_BIT-1; rx=1 -> IDLE, no flags (false start).
REQ-019 DATA/PARITY/STOP: sample rx when timer=0, then reload CLKS_PER_BIT-1; else decrement.
REQ-020 Data bit k SHALL be sampled H+(k+1)*CLKS_PER_BIT cycles after detection, shifted in LSB first.
REQ-021 After DATA_W samples -> PARITY if PARITY_MODE!=0, else STOP; PARITY samples one bit -> STOP.
REQ-022 Parity: even requires XOR(data,parity bit)=0; odd requires =1.
REQ-023 STOP: any stop sample rx=0 -> frame_err pulse next cycle, frame discarded, -> ERROR.
REQ-024 ERROR: stay until rx=1, then -> IDLE.
REQ-025 Last stop sample good -> IDLE directly (no dead cycle); new detection legal on next cycle.
REQ-026 Good stop + parity mismatch -> parity_err pulse, frame discarded; frame_err takes precedence.
REQ-027 Good frame: data/valid updated on the clock edge of the final stop sample (visible next cycle).
REQ-028 Good frame with valid=0, or valid=1 and ready=1 same cycle -> load data, valid=1.
REQ-029 Good frame with valid=1 and ready=0 -> overrun pulse, old data retained, new frame dropped.
REQ-030 valid&ready without frame completion -> valid=0 next cycle; data unchanged.
REQ-031 Timer width max(1,clog2(CLKS_PER_BIT)); bit index width clog2(DATA_W+1); no wrap within a frame.

Reset
REQ-032 rst SHALL force IDLE, timer=0, bit index=0, shift register=0, data=0, valid=0, all error pulses=0, busy=0.
REQ-033 rst mid-frame SHALL abandon the frame with no flags; first detection after rst release starts a fresh frame.

Structure
REQ-034 Package receiver_pkg SHALL hold state enum and PARITY_NONE/EVEN/ODD constants.
REQ-035 Sub-module rx_bit_timer SHALL own the down-counter (load, decrement, zero flag); FSM, shift register and output register stay in param_receiver.

Verification
REQ-036 DATA_W=8,N=1,no parity: rx 0,1,0,1,0,0,1,0,1,1 -> data=0xA5, valid=1 the cycle after stop sample, held until ready.
REQ-037 N=4: rx low 1 cycle then high -> START samples rx=1 at H=1 -> IDLE, valid=0, no flags.
REQ-038 PARITY_MODE=1, data 0x03, parity bit 1 -> parity_err single pulse, valid stays 0.
REQ-039 Stop bit 0 -> frame_err pulse, busy=1 in ERROR until rx=1, then next frame 0x5A received correctly.
REQ-040 ready=0, two back-to-back frames 0x11,0x22 -> data=0x11, overrun pulse on second; repeat with ready=1 at completion -> data=0x22, no overrun.
REQ-041 rst asserted after 3 data bits -> all outputs 0; next full frame 0x3C received correctly.

Source files
------------

// File: rtl/receiver_pkg.sv
// Shared types and constants for the parameterised serial receiver.
package receiver_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      ERROR
   } state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period down-counter: load has priority, decrement saturates at zero.
module rx_bit_timer #(
   parameter int unsigned TW = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   input  logic          dec,
   output logic          zero_c
);

   logic [TW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - TW'(1);
      end
   end

   assign zero_c = (count == '0);

endmodule

// File: rtl/param_receiver.sv
// Serial receiver: start/data/parity/stop framing with a one-word holding register.
module param_receiver
   import receiver_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 1,
   parameter int unsigned PARITY_MODE  = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   input  logic              ready,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              frame_err,
   output logic              parity_err,
   output logic              overrun,
   output logic              busy
);

   localparam int unsigned TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BW   = $clog2(DATA_W + 1);
   localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;

   localparam logic [TW-1:0] BIT_LOAD   = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] START_LOAD = TW'((HALF == 0) ? 0 : HALF - 1);
   localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_W - 1);
   localparam logic [BW-1:0] LAST_STOP  = BW'(STOP_BITS - 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BW-1:0]     bit_idx_q, bit_idx_d;
   logic              par_bad_q, par_bad_d;
   logic [DATA_W-1:0] data_d;
   logic              valid_d, frame_err_d, parity_err_d, overrun_d, busy_d;
   logic              tmr_load, tmr_dec, tmr_zero;
   logic [TW-1:0]     tmr_val;

   rx_bit_timer #(.TW(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero_c   (tmr_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         par_bad_q  <= 1'b0;
         data       <= '0;
         valid      <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         par_bad_q  <= par_bad_d;
         data       <= data_d;
         valid      <= valid_d;
         frame_err  <= frame_err_d;
         parity_err <= parity_err_d;
         overrun    <= overrun_d;
         busy       <= busy_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_idx_d    = bit_idx_q;
      par_bad_d    = par_bad_q;
      data_d       = data;
      valid_d      = valid;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      overrun_d    = 1'b0;
      tmr_load     = 1'b0;
      tmr_dec      = 1'b0;
      tmr_val      = BIT_LOAD;

      // Consumer handshake; a completing frame below may reassert valid.
      if (valid && ready) valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rx) begin
               tmr_load  = 1'b1;
               bit_idx_d = '0;
               par_bad_d = 1'b0;
               if (HALF == 0) begin
                  state_d = DATA;
               end else begin
                  state_d = START;
                  tmr_val = START_LOAD;
               end
            end
         end
         START: begin
            if (!tmr_zero) begin
               tmr_dec = 1'b1;
            end else if (!rx) begin
               state_d  = DATA;
               tmr_load = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         DATA: begin
            if (!tmr_zero) begin
               tmr_dec = 1'b1;
            end else begin
               tmr_load = 1'b1;
               shift_d  = (shift_q >> 1) | (DATA_W'(rx) << (DATA_W - 1));
               if (bit_idx_q == LAST_BIT) begin
                  bit_idx_d = '0;
                  state_d   = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
               end else begin
                  bit_idx_d = bit_idx_q + BW'(1);
               end
            end
         end
         PARITY: begin
            if (!tmr_zero) begin
               tmr_dec = 1'b1;
            end else begin
               tmr_load  = 1'b1;
               par_bad_d = (^shift_q) ^ rx ^ (PARITY_MODE == PARITY_ODD);
               bit_idx_d = '0;
               state_d   = STOP;
            end
         end
         STOP: begin
            if (!tmr_zero) begin
               tmr_dec = 1'b1;
            end else begin
               tmr_load = 1'b1;
               if (!rx) begin
                  frame_err_d = 1'b1;
                  state_d     = ERROR;
               end else if (bit_idx_q == LAST_STOP) begin
                  state_d = IDLE;
                  if (par_bad_q) begin
                     parity_err_d = 1'b1;
                  end else if (!valid || ready) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + BW'(1);
               end
            end
         end
         ERROR: begin
            if (rx) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_param_receiver.sv
// Directed bench: instance A (8N1, one clk/bit), instance B (4 clk/bit, even parity, 2 stop).
module tb_param_receiver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_a = 1'b1, ready_a = 1'b0;
   logic       rx_b = 1'b1, ready_b = 1'b0;
   logic [7:0] data_a, data_b;
   logic       valid_a, frame_err_a, parity_err_a, overrun_a, busy_a;
   logic       valid_b, frame_err_b, parity_err_b, overrun_b, busy_b;

   int vectors     = 0;
   int miscompares = 0;
   int pe_b = 0, fe_b = 0, ov_b = 0;

   always #5 clk = ~clk;

   param_receiver #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .rx(rx_a), .ready(ready_a), .data(data_a), .valid(valid_a),
      .frame_err(frame_err_a), .parity_err(parity_err_a), .overrun(overrun_a), .busy(busy_a)
   );

   param_receiver #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst(rst), .rx(rx_b), .ready(ready_b), .data(data_b), .valid(valid_b),
      .frame_err(frame_err_b), .parity_err(parity_err_b), .overrun(overrun_b), .busy(busy_b)
   );

   // Pulse-cycle counters for the slow instance, whose pulses fall mid-bit.
   always @(posedge clk) begin
      if (parity_err_b) pe_b <= pe_b + 1;
      if (frame_err_b)  fe_b <= fe_b + 1;
      if (overrun_b)    ov_b <= ov_b + 1;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_a(input logic b);
      rx_a = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [7:0] val, input logic stop, input logic rdy_stop);
      drive_a(1'b0);
      for (int i = 0; i < 8; i++) drive_a(val[i]);
      ready_a = rdy_stop;
      drive_a(stop);
      ready_a = 1'b0;
   endtask

   task automatic drive_b(input logic b);
      rx_b = b;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic send_b(input logic [7:0] val, input logic par, input logic s1, input logic s2);
      drive_b(1'b0);
      for (int i = 0; i < 8; i++) drive_b(val[i]);
      drive_b(par);
      drive_b(s1);
      drive_b(s2);
   endtask

   initial begin
      int pe0, fe0;

      // Reset state
      @(posedge clk); #1;
      check("rst_data_a", 16'(data_a), 16'h00);
      check("rst_flags_a", 16'({busy_a, valid_a, frame_err_a, parity_err_a, overrun_a}), 16'h0);
      check("rst_flags_b", 16'({busy_b, valid_b, frame_err_b, parity_err_b, overrun_b}), 16'h0);
      rst = 1'b0;
      drive_a(1'b1);
      drive_a(1'b1);

      // 0xA5 frame, held until ready
      send_a(8'hA5, 1'b1, 1'b0);
      check("a5_data", 16'(data_a), 16'hA5);
      check("a5_valid", 16'(valid_a), 16'h1);
      check("a5_busy", 16'(busy_a), 16'h0);
      repeat (3) drive_a(1'b1);
      check("a5_hold", 16'({valid_a, data_a}), 16'h1A5);
      ready_a = 1'b1;
      drive_a(1'b1);
      ready_a = 1'b0;
      check("a5_consumed", 16'({valid_a, data_a}), 16'h0A5);

      // Stop bit low: frame_err pulse, stay in ERROR while rx low
      send_a(8'h77, 1'b0, 1'b0);
      check("fe_pulse", 16'({frame_err_a, busy_a, valid_a}), 16'b110);
      drive_a(1'b0);
      check("fe_error_hold", 16'({frame_err_a, busy_a, valid_a}), 16'b010);
      drive_a(1'b1);
      check("fe_release", 16'(busy_a), 16'h0);
      send_a(8'h5A, 1'b1, 1'b0);
      check("after_fe_5a", 16'({valid_a, data_a}), 16'h15A);
      ready_a = 1'b1;
      drive_a(1'b1);
      ready_a = 1'b0;

      // Back-to-back frames with ready low: overrun, old data kept
      send_a(8'h11, 1'b1, 1'b0);
      check("ov_first", 16'({valid_a, data_a}), 16'h111);
      send_a(8'h22, 1'b1, 1'b0);
      check("ov_pulse", 16'({overrun_a, valid_a, data_a}), 16'h311);
      drive_a(1'b1);
      check("ov_pulse_end", 16'(overrun_a), 16'h0);
      send_a(8'h22, 1'b1, 1'b1);
      check("ov_ready_same", 16'({overrun_a, valid_a, data_a}), 16'h122);

      // Reset mid-frame after 3 data bits of 0x3C
      drive_a(1'b0);
      drive_a(1'b0);
      drive_a(1'b0);
      drive_a(1'b1);
      check("mid_busy", 16'(busy_a), 16'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_data", 16'(data_a), 16'h00);
      check("mid_rst_flags", 16'({busy_a, valid_a, frame_err_a, parity_err_a, overrun_a}), 16'h0);
      rx_a = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      drive_a(1'b1);
      check("post_rst_idle", 16'({busy_a, valid_a, frame_err_a}), 16'h0);
      send_a(8'h3C, 1'b1, 1'b0);
      check("post_rst_3c", 16'({valid_a, data_a}), 16'h13C);
      check("post_rst_flags", 16'({frame_err_a, parity_err_a, overrun_a}), 16'h0);

      // B: false start, one low cycle then high
      pe0 = pe_b;
      fe0 = fe_b;
      rx_b = 1'b0;
      @(posedge clk); #1;
      check("fs_start_busy", 16'(busy_b), 16'h1);
      rx_b = 1'b1;
      @(posedge clk); #1;
      check("fs_idle", 16'({busy_b, valid_b, frame_err_b, parity_err_b}), 16'h0);
      repeat (4) @(posedge clk);
      #1;

      // B: 0x03 with parity bit 1 under even parity
      send_b(8'h03, 1'b1, 1'b1, 1'b1);
      check("par_err_count", 16'(pe_b - pe0), 16'd1);
      check("par_no_fe", 16'(fe_b - fe0), 16'd0);
      check("par_valid", 16'({valid_b, busy_b}), 16'h0);

      // B: 0x07 with correct even parity bit 1
      send_b(8'h07, 1'b1, 1'b1, 1'b1);
      check("par_ok", 16'({valid_b, data_b}), 16'h107);
      check("par_ok_no_pe", 16'(pe_b - pe0), 16'd1);

      // B: second stop bit low takes frame_err
      send_b(8'h03, 1'b0, 1'b1, 1'b0);
      check("stop2_fe", 16'(fe_b - fe0), 16'd1);
      check("stop2_busy", 16'({busy_b, valid_b, data_b}), 16'h307);
      drive_b(1'b1);
      check("stop2_release", 16'(busy_b), 16'h0);
      check("b_no_overrun", 16'(ov_b), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
